// File: rtl/seg7_scan_driver_if.sv
// Display-side bundle for seg7_scan_driver: value/control inputs and scanned pin outputs.
// Decimal-point signals exist only when SEG7_DP_EN is defined.
interface seg7_scan_driver_if #(
  parameter int NUM_DIGITS = 4
);
  logic [4*NUM_DIGITS-1:0] value_in;
  logic                    load;
  logic [NUM_DIGITS-1:0]   digit_enable;
  logic                    lz_blank;
  logic [6:0]              seg_out;
  logic [NUM_DIGITS-1:0]   digit_sel;
  logic                    frame_done;
`ifdef SEG7_DP_EN
  logic [NUM_DIGITS-1:0]   dp_in;
  logic                    seg_dp;
`endif

`ifdef SEG7_DP_EN
  modport master (
    output value_in, load, digit_enable, lz_blank, dp_in,
    input  seg_out, digit_sel, frame_done, seg_dp
  );
  modport slave (
    input  value_in, load, digit_enable, lz_blank, dp_in,
    output seg_out, digit_sel, frame_done, seg_dp
  );
`else
  modport master (
    output value_in, load, digit_enable, lz_blank,
    input  seg_out, digit_sel, frame_done
  );
  modport slave (
    input  value_in, load, digit_enable, lz_blank,
    output seg_out, digit_sel, frame_done
  );
`endif
endinterface

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit common-anode 7-segment driver with enable mask and leading-zero blanking.
// Optional decimal-point output is enabled by defining SEG7_DP_EN.
module seg7_scan_driver #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int DIV_W       = 16
) (
  input logic               clk,
  input logic               rst,
  seg7_scan_driver_if.slave disp
);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic [DIV_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] value_q, value_d;
  logic [6:0]              seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   sel_q, sel_d;
  logic                    frame_q, frame_d;
  logic [NUM_DIGITS-1:0]   lz_mask;
  logic                    zero_run;
  logic [3:0]              nib;
  logic                    en_cur;
  logic                    lz_cur;
`ifdef SEG7_DP_EN
  logic                    dp_q, dp_d;
  logic                    dp_cur;
`endif

  function automatic logic [6:0] seg7_decode(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0011000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  // Prescaler, digit index and value latch
  always_comb begin
    cnt_d   = (cnt_q == DIV_LAST) ? '0 : cnt_q + DIV_W'(1);
    idx_d   = idx_q;
    if (cnt_q == DIV_LAST) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    end
    frame_d = (cnt_q == DIV_LAST) && (idx_q == IDX_LAST);
    value_d = disp.load ? disp.value_in : value_q;
  end

  // A digit is a leading zero when it and every higher nibble are zero; digit 0 always shows.
  always_comb begin
    zero_run = 1'b1;
    lz_mask  = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run   = zero_run & (value_q[4*i +: 4] == 4'h0);
      lz_mask[i] = zero_run && (i != 0);
    end
  end

  // Output stage: decode the currently indexed digit
  always_comb begin
    nib    = 4'h0;
    en_cur = 1'b0;
    lz_cur = 1'b0;
`ifdef SEG7_DP_EN
    dp_cur = 1'b0;
`endif
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        nib    = value_q[4*i +: 4];
        en_cur = disp.digit_enable[i];
        lz_cur = lz_mask[i];
`ifdef SEG7_DP_EN
        dp_cur = disp.dp_in[i];
`endif
      end
    end
    seg_d = (!en_cur || (disp.lz_blank && lz_cur)) ? 7'b1111111 : seg7_decode(nib);
    sel_d = ~(NUM_DIGITS'(1) << idx_q);
`ifdef SEG7_DP_EN
    dp_d  = en_cur ? ~dp_cur : 1'b1;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      value_q <= '0;
      seg_q   <= 7'b1111111;
      sel_q   <= '1;
      frame_q <= 1'b0;
`ifdef SEG7_DP_EN
      dp_q    <= 1'b1;
`endif
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      value_q <= value_d;
      seg_q   <= seg_d;
      sel_q   <= sel_d;
      frame_q <= frame_d;
`ifdef SEG7_DP_EN
      dp_q    <= dp_d;
`endif
    end
  end

  assign disp.seg_out    = seg_q;
  assign disp.digit_sel  = sel_q;
  assign disp.frame_done = frame_q;
`ifdef SEG7_DP_EN
  assign disp.seg_dp     = dp_q;
`endif
endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Parametrised, time-multiplexed driver for an N-digit common-anode 7-segment bank.
- Latches a packed hex word on a load strobe and scans one digit at a time at a programmable refresh rate.
- Supports a per-digit enable mask and optional leading-zero blanking.
- Sits between datapath/counter blocks and the board display pins; replaces per-digit combinational decoders.

Parameters:
- NUM_DIGITS, 4, number of digits scanned (1..8).
- REFRESH_DIV, 50000, clock cycles each digit stays selected (>=2).
- DIV_W, 16, width of prescaler counter; must satisfy 2**DIV_W >= REFRESH_DIV.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous reset, active-high.
- value_in  input  4*NUM_DIGITS  packed hex nibbles; nibble i drives digit i, digit 0 = LSB.
- load  input  1  on clock edge with load=1, value_in is latched into value_reg.
- digit_enable  input  NUM_DIGITS  per-digit enable; 0 forces that digit blank.
- lz_blank  input  1  1 = blank leading zeros.
- seg_out  output  7  segments {g,f,e,d,c,b,a}, active-low, registered.
- digit_sel  output  NUM_DIGITS  one-hot anode select, active-low, registered.
- frame_done  output  1  one-cycle pulse when scan wraps from digit NUM_DIGITS-1 to 0.

Behaviour:
- Reset: one clock; reset is synchronous and active-high. rst=1 at a clock edge clears prescaler, digit index and value_reg to 0, and sets seg_out=7'b1111111, digit_sel=all ones and frame_done=0. Reset mid-scan aborts the scan and restarts at digit 0 with a full REFRESH_DIV dwell.
- Prescaler:
  - Counts 0..REFRESH_DIV-1.
  - At REFRESH_DIV-1 it returns to 0 and the digit index advances.
  - The index wraps from NUM_DIGITS-1 to 0; frame_done=1 on the cycle the wrap is registered.
- Outputs:
  - Registered from the current index and value_reg, with one-cycle latency.
  - The first digit 0 output appears on the first edge after rst deasserts.
  - Each digit is held for exactly REFRESH_DIV cycles.
  - digit_sel has exactly one 0 at all times after reset exits.
- Decode (nibble -> seg_out, active-low gfedcba):
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000
  - 4 = 0011001, 5 = 0010010, 6 = 0000010, 7 = 1111000
  - 8 = 0000000, 9 = 0011000, A = 0001000, B = 0000011
  - C = 1000110, D = 0100001, E = 0000110, F = 0001110
  - Blank = 1111111.
- Blanking:
  - A digit is blank if digit_enable[i]=0.
  - With lz_blank=1, digit i is also blank when nibbles i..NUM_DIGITS-1 are all zero.
  - Digit 0 is never lz-blanked, so value 0 shows "0".
  - A blanked digit still occupies its time slot and digit_sel still selects it.
- Load:
  - load=1 updates value_reg on that edge; the new value is used from the next output update.
  - Load coincident with an index advance shows the new value on the newly selected digit.
  - load held high tracks value_in every cycle.
- digit_enable and lz_blank are sampled live, not latched.

Optional Feature:
- Macro SEG7_DP_EN.
- Defined:
  - Adds input dp_in [NUM_DIGITS-1:0] and output seg_dp [1], active-low and registered alongside seg_out.
  - seg_dp = ~dp_in[index], forced 1 when the digit is disabled via digit_enable.
  - Leading-zero blanking does not suppress the decimal point.
  - seg_dp resets to 1.
- Undefined: neither port exists; behaviour otherwise identical.

Test Plan:
1. Reset: rst high 3 cycles mid-scan -> seg_out=1111111, digit_sel=1111, frame_done=0. After release, digit_sel=1110 on the first edge.
2. Scan (NUM_DIGITS=4, REFRESH_DIV=4): load 16'h12AF, enable=1111, lz_blank=0.
   - Required sequence, each held exactly 4 cycles: digit_sel 1110/seg 0001110, 1101/0001000, 1011/0100100, 0111/1111001.
   - frame_done pulses once every 16 cycles at the 3->0 wrap.
3. Leading zeros: load 16'h0070, lz_blank=1 -> digit0 seg=1000000, digit1 seg=1111000, digits 2 and 3 seg=1111111. Load 16'h0000 -> digit0 shows 1000000 and digits 1-3 are blank.
4. Enable mask: value 16'h8888, enable=0101 -> digits 0 and 2 seg=0000000, digits 1 and 3 seg=1111111, digit_sel still cycles through all four.
5. Load at boundary: assert load with 16'h5555 on the exact cycle the index advances 0->1 -> digit 1 shows 0010010 immediately and no stale digit 1 value appears.
6. SEG7_DP_EN build: dp_in=0010, value 16'h3210 -> seg_dp=0 only while digit_sel=1101. With SEG7_DP_EN undefined, the bench compiles without dp ports.
